// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding request, strobes the data memory for WAIT_CYCLES.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects non-word-aligned byte addresses.
module mem_lsu #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0]  CNT_INIT    = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        memwrite_q;
  logic        memread_q;

  logic [31:0] word_idx;
  logic        out_of_range;
  logic        misalign;
  logic        req_bad;
  logic [3:0]  cnt_d;

  assign word_idx     = {2'b00, req_addr[31:2]};
  assign out_of_range = (word_idx >= MEM_WORDS_L);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = |req_addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign misalign        = 1'b0;
`endif

  assign req_bad = out_of_range | misalign;
  // Decrement saturates at zero so the counter can never wrap.
  assign cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              state_q <= RESP;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              state_q    <= ACCESS;
              addr_q     <= word_idx;
              wdata_q    <= req_wdata;
              write_q    <= req_write;
              cnt_q      <= CNT_INIT;
              memwrite_q <= req_write;
              memread_q  <= ~req_write;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q    <= RESP;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rdata_q    <= write_q ? 32'd0 : mem_read_data;
            err_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is masked while reset is held so no request can be taken during it.
  assign req_ready      = (state_q == IDLE) && rst_n;
  assign resp_valid     = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_memwrite   = memwrite_q;
  assign mem_memread    = memread_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: WAIT_CYCLES=1 instance driven from a vector table with a
// response scoreboard, WAIT_CYCLES=3 instance for backpressure and reset corners.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1 = 0, wr1 = 0, rr1 = 0;
  logic [31:0] addr1 = 0, wd1 = 0;
  logic        rdy1, rv1, err1, mw1, mr1, busy1;
  logic [31:0] rd1, ma1, mwd1, mrd1;

  logic        v3 = 0, wr3 = 0, rr3 = 0;
  logic [31:0] addr3 = 0, wd3 = 0;
  logic        rdy3, rv3, err3, mw3, mr3, busy3;
  logic [31:0] rd3, ma3, mwd3, mrd3;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  mem_lsu #(.WAIT_CYCLES(1), .MEM_WORDS(256)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1), .req_write(wr1), .req_addr(addr1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_ready(rr1), .resp_rdata(rd1), .resp_err(err1),
    .mem_addr(ma1), .mem_write_data(mwd1), .mem_memwrite(mw1), .mem_memread(mr1),
    .mem_read_data(mrd1), .busy(busy1)
  );

  mem_lsu #(.WAIT_CYCLES(3), .MEM_WORDS(256)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(rdy3), .req_write(wr3), .req_addr(addr3), .req_wdata(wd3),
    .resp_valid(rv3), .resp_ready(rr3), .resp_rdata(rd3), .resp_err(err3),
    .mem_addr(ma3), .mem_write_data(mwd3), .mem_memwrite(mw3), .mem_memread(mr3),
    .mem_read_data(mrd3), .busy(busy3)
  );

  // Behavioural data memories: combinational read, write on the strobe edge.
  assign mrd1 = mem1[ma1[7:0]];
  assign mrd3 = mem3[ma3[7:0]];
  always @(posedge clk) begin
    if (mw1) mem1[ma1[7:0]] <= mwd1;
    if (mw3) mem3[ma3[7:0]] <= mwd3;
  end

  int sw1 = 0, sr1 = 0, sw3 = 0, sr3 = 0;
  always @(negedge clk) begin
    if (mw1) sw1 <= sw1 + 1;
    if (mr1) sr1 <= sr1 + 1;
    if (mw3) sw3 <= sw3 + 1;
    if (mr3) sr3 <= sr3 + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];

  task automatic run_vec(input vec_t v, input int idx);
    int k, s0w, s0r, exp_lat;
    vec_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    wr1 = v.write; addr1 = v.addr; wd1 = v.wdata; v1 = 1'b1; rr1 = 1'b1;
    k = 0;
    while (!rdy1 && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_req_ready"}, 32'(rdy1), 32'd1);
    @(posedge clk);
    s0w = sw1; s0r = sr1;
    sb.push_back(v);
    #1 v1 = 1'b0;
    k = 1;
    while (!rv1 && k < 40) begin @(posedge clk); #1; k++; end
    e = sb.pop_front();
    exp_lat = e.exp_err ? 1 : 2;
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err1), 32'(e.exp_err));
    chk({tag, "_rdata"}, rd1, e.exp_rdata);
    chk({tag, "_wstrobes"}, 32'(sw1 - s0w), (e.write && !e.exp_err) ? 32'd1 : 32'd0);
    chk({tag, "_rstrobes"}, 32'(sr1 - s0r), (!e.write && !e.exp_err) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {30'd0, rdy1, rv1}, 32'd2);
  endtask

  task automatic run3(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
    int k, s0w, s0r;
    logic [31:0] rd_hold;
    logic err_hold, stable;
    @(negedge clk);
    wr3 = w; addr3 = a; wd3 = d; v3 = 1'b1; rr3 = 1'b0;
    chk({tag, "_req_ready"}, 32'(rdy3), 32'd1);
    @(posedge clk);
    s0w = sw3; s0r = sr3;
    #1 v3 = 1'b0;
    k = 1;
    while (!rv3 && k < 40) begin @(posedge clk); #1; k++; end
    chk({tag, "_latency"}, 32'(k), 32'd4);
    chk({tag, "_wstrobes"}, 32'(sw3 - s0w), w ? 32'd3 : 32'd0);
    chk({tag, "_rstrobes"}, 32'(sr3 - s0r), w ? 32'd0 : 32'd3);
    chk({tag, "_rdata"}, rd3, exp_rd);
    chk({tag, "_err"}, 32'(err3), 32'd0);
    rd_hold = rd3; err_hold = err3; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rv3 || rd3 !== rd_hold || err3 !== err_hold || rdy3 !== 1'b0) stable = 1'b0;
    end
    chk({tag, "_stall_stable"}, 32'(stable), 32'd1);
    @(negedge clk); rr3 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ready_after_hs"}, {30'd0, rdy3, rv3}, 32'd2);
    @(negedge clk); rr3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_resp;
    for (int i = 0; i < 256; i++) begin mem1[i] = 32'd0; mem3[i] = 32'd0; end

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[3] = '{1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0};
`else
    vecs[3] = '{1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'hDEAD_BEEF};
`endif
    vecs[4] = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h1234_5678};
    vecs[6] = '{1'b1, 32'hFFFF_FFF0, 32'h5555_AAAA, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};

    // Reset state, sampled while reset is held.
    #12;
    chk("rst_outputs", {26'd0, rv1, err1, mw1, mr1, busy1, rdy1}, 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_mem_addr", ma1, 32'd0);
    chk("rst_mem_wdata", mwd1, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", {30'd0, rdy1, rdy3}, 32'd3);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        chk("store_mem_addr", ma1, 32'd4);
        chk("store_mem_wdata", mwd1, 32'hDEAD_BEEF);
      end
      if (i == 2) chk("err_holds_mem_addr", ma1, 32'd4);
      if (i == 6) chk("oor_store_no_write", mem1[8'h3C], 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);

    run3(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, "w3_store");
    run3(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, "w3_load");

    // Reset asserted mid-ACCESS between clock edges.
    @(negedge clk);
    wr3 = 1'b0; addr3 = 32'h0000_0020; v3 = 1'b1; rr3 = 1'b1;
    @(posedge clk); #1 v3 = 1'b0;
    chk("midrst_strobe_before", 32'(mr3), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async_drop", {29'd0, mr3, busy3, rv3}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rv3) saw_resp = 1'b1;
    end
    chk("midrst_no_response", 32'(saw_resp), 32'd0);
    chk("midrst_ready_after", 32'(rdy3), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
